tetris_drop_scheduler: RTL and testbench

Gravity and lock-delay scheduler for the falling piece. It replaces free-running toggled slow clocks with single-cycle enable pulses in the `Clk` domain. It issues `drop_tick` at a level-dependent rate, with soft-drop and hard-drop overrides, pause, and a lock-delay timer that requests piece lock. It sits between the game-control FSM (spawn, level, pause, buttons) and the playfield/piece-move logic (`landed` feedback, consumes `drop_tick`/`lock_req`).

---
 rtl/tetris_drop_scheduler.sv | 157 +++++++++++++++
 tb/tb_tetris_drop_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_drop_scheduler.sv
//==============================================================================
// Module   : tetris_drop_scheduler
// Purpose  : Level-dependent gravity and lock-delay scheduler that issues
//            one-cycle drop_tick / lock_req enables in the Clk domain.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tetris_drop_scheduler #(
    parameter int CNT_W       = 20,
    parameter int BASE_PERIOD = 750000,
    parameter int LEVEL_STEP  = 50000,
    parameter int MIN_PERIOD  = 50000,
    parameter int SOFT_PERIOD = 40000,
    parameter int LOCK_CYCLES = 300000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       spawn,
    input  logic       pause,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       hard_drop,
    input  logic       landed,
    output logic       drop_tick,
    output logic       lock_req,
    output logic [1:0] state
);

    localparam int c_pw = CNT_W + 4;

    localparam logic [c_pw-1:0]  c_base      = c_pw'(BASE_PERIOD);
    localparam logic [c_pw-1:0]  c_step      = c_pw'(LEVEL_STEP);
    localparam logic [c_pw-1:0]  c_min       = c_pw'(MIN_PERIOD);
    localparam logic [c_pw-1:0]  c_soft      = c_pw'(SOFT_PERIOD);
    localparam logic [c_pw-1:0]  c_pw_one    = c_pw'(1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_LOCK = 2'd2,
        ST_HARD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_gcnt;
    logic [CNT_W-1:0] w_gcnt_nxt;
    logic [CNT_W-1:0] r_lcnt;
    logic [CNT_W-1:0] w_lcnt_nxt;
    logic             r_drop_tick;
    logic             w_drop_tick_nxt;
    logic             r_lock_req;
    logic             w_lock_req_nxt;

    logic [c_pw-1:0]  w_lvl_step;
    logic [c_pw-1:0]  w_level_period;
    logic [c_pw-1:0]  w_period;
    logic             w_gravity_due;

    // Compare before subtracting so high levels clamp to the floor without underflow.
    assign w_lvl_step     = {{(c_pw-4){1'b0}}, level} * c_step;
    assign w_level_period = (w_lvl_step >= (c_base - c_min)) ? c_min : (c_base - w_lvl_step);
    assign w_period       = (soft_drop && (w_level_period > c_soft)) ? c_soft : w_level_period;

    // >= so that a period shortened mid-count fires immediately rather than wrapping.
    assign w_gravity_due  = ({4'b0000, r_gcnt} >= (w_period - c_pw_one));

    always_comb begin
        w_state_nxt     = r_state;
        w_gcnt_nxt      = r_gcnt;
        w_lcnt_nxt      = r_lcnt;
        w_drop_tick_nxt = 1'b0;
        w_lock_req_nxt  = 1'b0;

        if (spawn) begin
            w_state_nxt = ST_FALL;
            w_gcnt_nxt  = c_cnt_zero;
            w_lcnt_nxt  = c_cnt_zero;
        end else if (!pause) begin
            case (r_state)
                ST_IDLE: begin
                    w_gcnt_nxt = c_cnt_zero;
                    w_lcnt_nxt = c_cnt_zero;
                end
                ST_FALL: begin
                    if (hard_drop) begin
                        w_state_nxt = ST_HARD;
                        w_gcnt_nxt  = c_cnt_zero;
                    end else if (w_gravity_due) begin
                        w_gcnt_nxt = c_cnt_zero;
                        if (landed) begin
                            w_state_nxt = ST_LOCK;
                            w_lcnt_nxt  = c_cnt_zero;
                        end else begin
                            w_drop_tick_nxt = 1'b1;
                        end
                    end else begin
                        w_gcnt_nxt = r_gcnt + c_cnt_one;
                    end
                end
                ST_LOCK: begin
                    if (!landed) begin
                        w_state_nxt = ST_FALL;
                        w_gcnt_nxt  = c_cnt_zero;
                    end else if (hard_drop || (r_lcnt == c_lock_last)) begin
                        w_lock_req_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        w_gcnt_nxt     = c_cnt_zero;
                        w_lcnt_nxt     = c_cnt_zero;
                    end else begin
                        w_lcnt_nxt = r_lcnt + c_cnt_one;
                    end
                end
                ST_HARD: begin
                    if (landed) begin
                        w_lock_req_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        w_gcnt_nxt     = c_cnt_zero;
                        w_lcnt_nxt     = c_cnt_zero;
                    end else begin
                        w_drop_tick_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_gcnt      <= c_cnt_zero;
            r_lcnt      <= c_cnt_zero;
            r_drop_tick <= 1'b0;
            r_lock_req  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_drop_tick <= w_drop_tick_nxt;
            r_lock_req  <= w_lock_req_nxt;
        end
    end

    assign drop_tick = r_drop_tick;
    assign lock_req  = r_lock_req;
    assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_tetris_drop_scheduler.sv
//==============================================================================
// Module   : tb_tetris_drop_scheduler
// Purpose  : Directed self-checking bench for tetris_drop_scheduler.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tetris_drop_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       spawn;
    logic       pause;
    logic [3:0] level;
    logic       soft_drop;
    logic       hard_drop;
    logic       landed;
    logic       drop_tick;
    logic       lock_req;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    tetris_drop_scheduler #(
        .CNT_W       (8),
        .BASE_PERIOD (20),
        .LEVEL_STEP  (4),
        .MIN_PERIOD  (4),
        .SOFT_PERIOD (3),
        .LOCK_CYCLES (5)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .spawn     (spawn),
        .pause     (pause),
        .level     (level),
        .soft_drop (soft_drop),
        .hard_drop (hard_drop),
        .landed    (landed),
        .drop_tick (drop_tick),
        .lock_req  (lock_req),
        .state     (state)
    );

    // Advance one rising edge and settle just after it.
    task automatic clk_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Reset     = 1'b0;
        spawn     = 1'b0;
        pause     = 1'b0;
        soft_drop = 1'b0;
        hard_drop = 1'b0;
        landed    = 1'b0;
    endtask

    // The spawn edge is edge 0 of each scenario.
    task automatic do_spawn();
        spawn = 1'b1;
        clk_edge();
        spawn = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_tick;
        clear_inputs();
        level = 4'd0;
        Reset = 1'b1;
        clk_edge();
        clk_edge();
        Reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            clk_edge();
            n_checks++;
            if (drop_tick !== 1'b0 || lock_req !== 1'b0 || state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_idle edge %0d: got tick=%b lock=%b state=%0d, want 0/0/0", e, drop_tick, lock_req, state);
            end
        end
        do_spawn();
        n_checks++;
        if (state !== 2'd1 || drop_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL spawn_state: got state=%0d tick=%b, want 1/0", state, drop_tick);
        end
        for (int e = 1; e <= 60; e++) begin
            clk_edge();
            exp_tick = ((e % 20) == 0);
            n_checks++;
            if (drop_tick !== exp_tick || lock_req !== 1'b0) begin
                n_fail++;
                $display("FAIL level0_tick edge %0d: got tick=%b lock=%b, want %b/0", e, drop_tick, lock_req, exp_tick);
            end
        end
    endtask

    task automatic test_levels();
        int   lv [6] = '{2, 9, 15, 2, 9, 4};
        int   sd [6] = '{0, 0, 0, 1, 1, 0};
        int   pp [6] = '{12, 4, 4, 3, 3, 4};
        logic exp_tick;
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            level     = 4'(lv[i]);
            soft_drop = (sd[i] != 0);
            do_spawn();
            for (int e = 1; e <= 3 * pp[i]; e++) begin
                clk_edge();
                exp_tick = ((e % pp[i]) == 0);
                n_checks++;
                if (drop_tick !== exp_tick) begin
                    n_fail++;
                    $display("FAIL level_period lvl=%0d soft=%0d edge %0d: got tick=%b, want %b", lv[i], sd[i], e, drop_tick, exp_tick);
                end
            end
        end
        soft_drop = 1'b0;
    endtask

    task automatic test_level_change();
        logic exp_tick;
        clear_inputs();
        level = 4'd0;
        do_spawn();
        for (int e = 1; e <= 10; e++) clk_edge();
        level = 4'd9;
        for (int e = 11; e <= 22; e++) begin
            clk_edge();
            exp_tick = (((e - 11) % 4) == 0);
            n_checks++;
            if (drop_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL level_change edge %0d: got tick=%b, want %b", e, drop_tick, exp_tick);
            end
        end
    endtask

    task automatic test_lock();
        logic exp_tick;
        logic exp_lock;
        clear_inputs();
        level = 4'd0;
        // Full lock delay.
        do_spawn();
        for (int e = 1; e <= 39; e++) clk_edge();
        landed = 1'b1;
        clk_edge();
        n_checks++;
        if (drop_tick !== 1'b0 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_enter: got tick=%b state=%0d, want 0/2", drop_tick, state);
        end
        for (int e = 41; e <= 46; e++) begin
            clk_edge();
            exp_lock = (e == 45);
            n_checks++;
            if (lock_req !== exp_lock || drop_tick !== 1'b0 || state !== ((e >= 45) ? 2'd0 : 2'd2)) begin
                n_fail++;
                $display("FAIL lock_delay edge %0d: got lock=%b tick=%b state=%0d, want lock=%b", e, lock_req, drop_tick, state, exp_lock);
            end
        end
        // Slide off an edge at lcnt=2.
        landed = 1'b0;
        do_spawn();
        for (int e = 1; e <= 39; e++) clk_edge();
        landed = 1'b1;
        for (int e = 40; e <= 42; e++) clk_edge();
        landed = 1'b0;
        clk_edge();
        n_checks++;
        if (state !== 2'd1 || lock_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_slide_state: got state=%0d lock=%b, want 1/0", state, lock_req);
        end
        for (int e = 44; e <= 63; e++) begin
            clk_edge();
            exp_tick = (e == 63);
            n_checks++;
            if (drop_tick !== exp_tick || lock_req !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_slide_tick edge %0d: got tick=%b lock=%b, want %b/0", e, drop_tick, lock_req, exp_tick);
            end
        end
    endtask

    task automatic test_pause();
        logic exp_tick;
        clear_inputs();
        level = 4'd0;
        do_spawn();
        for (int e = 1; e <= 10; e++) clk_edge();
        pause = 1'b1;
        for (int e = 11; e <= 17; e++) begin
            clk_edge();
            n_checks++;
            if (drop_tick !== 1'b0 || lock_req !== 1'b0 || state !== 2'd1) begin
                n_fail++;
                $display("FAIL pause_hold edge %0d: got tick=%b lock=%b state=%0d, want 0/0/1", e, drop_tick, lock_req, state);
            end
        end
        pause = 1'b0;
        for (int e = 18; e <= 27; e++) begin
            clk_edge();
            exp_tick = (e == 27);
            n_checks++;
            if (drop_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL pause_delay edge %0d: got tick=%b, want %b", e, drop_tick, exp_tick);
            end
        end
        // gcnt=5 when spawn arrives under pause; it must restart from 0.
        for (int e = 1; e <= 5; e++) clk_edge();
        pause = 1'b1;
        do_spawn();
        n_checks++;
        if (state !== 2'd1 || drop_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_spawn_state: got state=%0d tick=%b, want 1/0", state, drop_tick);
        end
        clk_edge();
        clk_edge();
        pause = 1'b0;
        for (int e = 3; e <= 22; e++) begin
            clk_edge();
            exp_tick = (e == 22);
            n_checks++;
            if (drop_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL pause_spawn_tick edge %0d: got tick=%b, want %b", e, drop_tick, exp_tick);
            end
        end
    endtask

    task automatic test_hard_drop();
        clear_inputs();
        level = 4'd0;
        do_spawn();
        for (int e = 1; e <= 5; e++) clk_edge();
        hard_drop = 1'b1;
        clk_edge();
        hard_drop = 1'b0;
        n_checks++;
        if (state !== 2'd3 || drop_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL hard_enter: got state=%0d tick=%b, want 3/0", state, drop_tick);
        end
        for (int e = 7; e <= 9; e++) begin
            clk_edge();
            n_checks++;
            if (drop_tick !== 1'b1 || lock_req !== 1'b0 || state !== 2'd3) begin
                n_fail++;
                $display("FAIL hard_tick edge %0d: got tick=%b lock=%b state=%0d, want 1/0/3", e, drop_tick, lock_req, state);
            end
        end
        landed = 1'b1;
        clk_edge();
        n_checks++;
        if (lock_req !== 1'b1 || drop_tick !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL hard_lock: got lock=%b tick=%b state=%0d, want 1/0/0", lock_req, drop_tick, state);
        end
        clk_edge();
        n_checks++;
        if (lock_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hard_lock_pulse: got lock=%b, want 0", lock_req);
        end
        // Hard drop while in lock delay.
        landed = 1'b0;
        level  = 4'd9;
        do_spawn();
        for (int e = 1; e <= 3; e++) clk_edge();
        landed = 1'b1;
        clk_edge();
        clk_edge();
        n_checks++;
        if (state !== 2'd2 || lock_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hard_in_lock_pre: got state=%0d lock=%b, want 2/0", state, lock_req);
        end
        hard_drop = 1'b1;
        clk_edge();
        hard_drop = 1'b0;
        n_checks++;
        if (lock_req !== 1'b1 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL hard_in_lock: got lock=%b state=%0d, want 1/0", lock_req, state);
        end
        clk_edge();
        n_checks++;
        if (lock_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hard_in_lock_pulse: got lock=%b, want 0", lock_req);
        end
        landed = 1'b0;
    endtask

    task automatic test_reset_in_lock();
        clear_inputs();
        level = 4'd9;
        do_spawn();
        for (int e = 1; e <= 3; e++) clk_edge();
        landed = 1'b1;
        for (int e = 4; e <= 7; e++) clk_edge();
        Reset = 1'b1;
        clk_edge();
        n_checks++;
        if (state !== 2'd0 || drop_tick !== 1'b0 || lock_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_lock: got state=%0d tick=%b lock=%b, want 0/0/0", state, drop_tick, lock_req);
        end
        Reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            clk_edge();
            n_checks++;
            if (lock_req !== 1'b0 || state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_in_lock_after edge %0d: got lock=%b state=%0d, want 0/0", e, lock_req, state);
            end
        end
        // Reset and spawn together.
        landed = 1'b0;
        level  = 4'd0;
        Reset  = 1'b1;
        spawn  = 1'b1;
        clk_edge();
        Reset  = 1'b0;
        spawn  = 1'b0;
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_beats_spawn: got state=%0d, want 0", state);
        end
        for (int e = 1; e <= 25; e++) begin
            clk_edge();
            n_checks++;
            if (drop_tick !== 1'b0 || state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_beats_spawn_idle edge %0d: got tick=%b state=%0d, want 0/0", e, drop_tick, state);
            end
        end
    endtask

    initial begin
        clear_inputs();
        level = 4'd0;
        test_reset();
        test_levels();
        test_level_change();
        test_lock();
        test_pause();
        test_hard_drop();
        test_reset_in_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
